display_write_scheduler: RTL and testbench
==========================================

Name: display_write_scheduler

Overview:
- Sits between display_instruction_dispatcher and the character buffer RAM write port.
- Queues single-cycle DISPLAY writes in a small FIFO and replays them into the RAM.
- Runs a screen-clear sequencer that fills the buffer with spaces.
- Shares the single RAM port with the VGA scan reader, which always has priority.

Parameters:
FIFO_DEPTH, 8, write queue entries; power of 2, minimum 2
SCREEN_CHARS, 2400, number of valid character cells (80x30); positions >= this are discarded
CLEAR_CHAR, 7'h20, code written into every cell during a clear

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request pulse from dispatcher (buffer_write_enable)
wr_position  in  12  target cell
wr_char  in  7  character code
clear_req  in  1  single-cycle pulse requesting a full-screen clear
vga_req  in  1  VGA reader owns the RAM port this cycle; scheduler must not write
ram_we  out  1  registered RAM write strobe
ram_addr  out  12  registered RAM address
ram_data  out  7  registered RAM data
fifo_full  out  1  count == FIFO_DEPTH; CPU pipeline stalls DISPLAY issue on this
busy  out  1  FIFO non-empty, or state != IDLE, or clear pending
overflow  out  1  sticky; set when a write is dropped because the FIFO is full; cleared only by reset

Behaviour:
- Reset (async on rst_n low, released synchronously by design use):
  - ram_we=0, ram_addr=0, ram_data=0.
  - FIFO empty, overflow=0, clear_pending=0, state=IDLE.
  - Reset mid-clear or mid-drain abandons the operation and drops all queued entries.
- Push: on a clk edge with wr_en=1:
  - If wr_position >= SCREEN_CHARS, the entry is silently discarded and not queued.
  - Else, if count < FIFO_DEPTH, the entry {position, char} is queued.
  - Else the entry is dropped and overflow is set.
  - Full is judged on the registered count. A push while full is dropped even if a pop occurs in the same cycle.
- Pop/issue: each cycle the scheduler drives at most one RAM write.
  - No write is issued in any cycle where vga_req=1: ram_we=0 the following cycle and no state advances.
- States:
  - IDLE:
    - If clear_pending and the FIFO is empty -> CLEAR with clear_addr=0.
    - Else if the FIFO is non-empty and vga_req=0 -> pop head; next cycle ram_we=1 with its addr/data (DRAIN behaviour, stays IDLE).
  - CLEAR:
    - Each cycle with vga_req=0, write CLEAR_CHAR at clear_addr, then clear_addr++.
    - After writing SCREEN_CHARS-1 -> IDLE and clear_pending=0.
    - CPU pushes during CLEAR are queued, not issued, and are applied after the clear.
- Ordering:
  - clear_req sets clear_pending.
  - Entries already in the FIFO when clear_req arrives are drained before CLEAR starts. This costs extra cycles, but ordering is preserved.
  - clear_req while clear_pending=1 or in CLEAR is ignored (no restart).
- Latency:
  - Write accepted at edge N with an empty FIFO, idle state and vga_req=0 -> ram_we=1 during cycle N+1.
  - Throughput is 1 write per cycle.
  - Pass-through (push and pop of the same entry) is not required; minimum latency is 1 cycle.
- Simultaneous push and pop: both occur and count is unchanged.
- Full clear duration: SCREEN_CHARS cycles plus the number of vga_req-high cycles.
- fifo_full and busy are combinational from registered state only.

Optional Feature:
DISPLAY_WRITE_DROP_COUNT_EN
- Defined:
  - Adds output drop_count[7:0], reset 0.
  - Increments, saturating at 255, on every dropped write: both FIFO-full drops and out-of-range-position drops.
- Undefined: port absent; out-of-range writes discarded silently; overflow still reports FIFO-full drops.

Test Plan:
- Single write: wr_en pulse, position 0x005, char 0x41, vga_req=0 -> next cycle ram_we=1, ram_addr=0x005, ram_data=0x41; busy drops the cycle after.
- VGA priority: queue 3 writes (positions 1, 2, 3) while vga_req=1 for 10 cycles -> ram_we=0 throughout; after vga_req falls, writes 1, 2, 3 appear on consecutive cycles in order.
- Overflow: vga_req=1, push 9 writes with FIFO_DEPTH=8 -> fifo_full=1 after the 8th; the 9th is dropped; overflow=1; only 8 RAM writes occur after release.
- Range check: write position 2400 and 4095 -> no RAM write, not queued; overflow stays 0. With DISPLAY_WRITE_DROP_COUNT_EN, drop_count=2.
- Clear ordering:
  - Queue writes A@10, B@20; then clear_req; then write C@30 during CLEAR.
  - Required RAM sequence: A, B, then 2400 writes of 0x20 at addrs 0..2399, then C.
  - A second clear_req mid-clear has no effect.
- Reset mid-clear: assert rst_n=0 at clear_addr=1000 -> outputs immediately 0, FIFO empty, busy=0 after release; no further RAM writes.

Source files
------------

// File: rtl/display_write_scheduler.sv
// display_write_scheduler
// Queues DISPLAY writes from the instruction dispatcher in a small FIFO and
// replays them into the single-port character buffer RAM. A screen-clear
// sequencer fills every valid cell with CLEAR_CHAR. The VGA scan reader owns
// the RAM port whenever vga_req is high; the scheduler then issues nothing
// and no state advances.
// Optional build macro: DISPLAY_WRITE_DROP_COUNT_EN adds a saturating
// drop_count output counting FIFO-full and out-of-range drops.
module display_write_scheduler #(
  parameter int         FIFO_DEPTH   = 8,
  parameter int         SCREEN_CHARS = 2400,
  parameter logic [6:0] CLEAR_CHAR   = 7'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [11:0] wr_position,
  input  logic [6:0]  wr_char,
  input  logic        clear_req,
  input  logic        vga_req,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [6:0]  ram_data,
  output logic        fifo_full,
  output logic        busy,
  output logic        overflow
`ifdef DISPLAY_WRITE_DROP_COUNT_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [12:0] SCREEN_LIM = 13'(SCREEN_CHARS);
  localparam logic [11:0] LAST_ADDR  = 12'(SCREEN_CHARS - 1);

  typedef struct packed {
    logic [11:0] pos;
    logic [6:0]  chr;
  } entry_t;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  entry_t      r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  entry_t      w_head;

  logic        r_clear_pending;
  logic [11:0] r_clear_addr;
  logic        r_overflow;

  logic        r_ram_we;
  logic [11:0] r_ram_addr;
  logic [6:0]  r_ram_data;

  logic        w_in_range;
  logic        w_push;
  logic        w_drop_full;
  logic        w_pop;
  logic        w_clear_wr;
  logic        w_clear_start;
  logic        w_clear_done;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == DEPTH_C);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // Full is judged on the registered count only, so a pop in the same cycle
  // does not rescue a push made while full.
  assign w_in_range  = ({1'b0, wr_position} < SCREEN_LIM);
  assign w_push      = wr_en & w_in_range & ~w_full;
  assign w_drop_full = wr_en & w_in_range & w_full;

  assign fifo_full = w_full;
  assign busy      = ~w_empty | (r_state != S_IDLE) | r_clear_pending;
  assign overflow  = r_overflow;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state: a clear starts only once earlier writes have drained, and
  // nothing advances while the VGA reader holds the port.
  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (r_clear_pending && w_empty && !vga_req) w_next_state = S_CLEAR;
      S_CLEAR: if (!vga_req && (r_clear_addr == LAST_ADDR)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-state actions: drain the FIFO in IDLE, emit clear writes in CLEAR.
  always_comb begin
    w_pop         = 1'b0;
    w_clear_wr    = 1'b0;
    w_clear_start = 1'b0;
    w_clear_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clear_start = r_clear_pending & w_empty & ~vga_req;
        w_pop         = ~w_empty & ~vga_req;
      end
      S_CLEAR: begin
        w_clear_wr   = ~vga_req;
        w_clear_done = ~vga_req & (r_clear_addr == LAST_ADDR);
      end
      default: ;
    endcase
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is not reset; validity is tracked by the
    // pointers, so reset only needs to clear them.
    if (w_push) r_mem[r_wptr[AW-1:0]] <= '{pos: wr_position, chr: wr_char};
  end

  // FIFO pointers; reset drops every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Clear bookkeeping: a request is latched once and ignored until the
  // sequence in progress has written the last cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clear_pending <= 1'b0;
      r_clear_addr    <= '0;
    end else begin
      if (w_clear_done)   r_clear_pending <= 1'b0;
      else if (clear_req) r_clear_pending <= 1'b1;

      if (w_clear_start)   r_clear_addr <= '0;
      else if (w_clear_wr) r_clear_addr <= r_clear_addr + 12'd1;
    end
  end

  // Sticky overflow flag for writes lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overflow <= 1'b0;
    else if (w_drop_full) r_overflow <= 1'b1;
  end

  // Registered RAM write port; address and data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else begin
      r_ram_we <= w_pop | w_clear_wr;
      if (w_pop) begin
        r_ram_addr <= w_head.pos;
        r_ram_data <= w_head.chr;
      end else if (w_clear_wr) begin
        r_ram_addr <= r_clear_addr;
        r_ram_data <= CLEAR_CHAR;
      end
    end
  end

`ifdef DISPLAY_WRITE_DROP_COUNT_EN
  logic [7:0] r_drop_count;
  logic       w_drop_any;

  assign w_drop_any = wr_en & (~w_in_range | w_full);
  assign drop_count = r_drop_count;

  // Saturating count of every dropped write, full or out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop_count <= '0;
    else if (w_drop_any && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_display_write_scheduler.sv
// Testbench for display_write_scheduler: randomized and directed stimulus,
// a reference model of queue occupancy and ordering, and a scoreboard
// monitor that checks every RAM write against the expected sequence.
module tb_display_write_scheduler;

  localparam int DEPTH  = 8;
  localparam int SCREEN = 2400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [11:0] wr_position;
  logic [6:0]  wr_char;
  logic        clear_req;
  logic        vga_req;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [6:0]  ram_data;
  logic        fifo_full;
  logic        busy;
  logic        overflow;
`ifdef DISPLAY_WRITE_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  display_write_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .SCREEN_CHARS(SCREEN),
    .CLEAR_CHAR  (7'h20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_position(wr_position),
    .wr_char    (wr_char),
    .clear_req  (clear_req),
    .vga_req    (vga_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .overflow   (overflow)
`ifdef DISPLAY_WRITE_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [18:0] exp_q[$];     // {addr, data} of RAM writes still owed
  int          occ      = 0; // model queue occupancy
  logic        exp_ovf  = 1'b0;
  int          exp_drops = 0;
  logic        mon_en   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every RAM write must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && mon_en && ram_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {13'd0, ram_addr, ram_data}, 32'h7FFFF);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("ram_write", {13'd0, ram_addr, ram_data}, {13'd0, e});
      end
    end
  end

  // One cycle outside any clear: drive at the negedge, let the model decide
  // acceptance and issue from the pre-edge occupancy, then check afterwards.
  task automatic step(input logic we, input logic [11:0] pos, input logic [6:0] ch,
                      input logic vga);
    logic exp_pop;
    int   acc;
    wr_en = we; wr_position = pos; wr_char = ch; vga_req = vga; clear_req = 1'b0;
    acc = 0;
    exp_pop = (occ > 0) && !vga;
    if (we) begin
      if (int'(pos) >= SCREEN) begin
        exp_drops++;
      end else if (occ < DEPTH) begin
        exp_q.push_back({pos, ch});
        acc = 1;
      end else begin
        exp_ovf = 1'b1;
        exp_drops++;
      end
    end
    occ = occ + acc - (exp_pop ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    check("ram_we", 32'(ram_we), 32'(exp_pop));
    check("fifo_full", 32'(fifo_full), 32'(occ == DEPTH));
    check("busy", 32'(busy), 32'(occ > 0));
    check("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 12'd0, 7'd0, 1'b0);
  endtask

  initial begin
    int          cyc;
    logic        found;
    logic [11:0] rp;

    rst_n = 1'b0; wr_en = 1'b0; wr_position = '0; wr_char = '0;
    clear_req = 1'b0; vga_req = 1'b0;
    #12;
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_data", 32'(ram_data), 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write.
    step(1'b1, 12'h005, 7'h41, 1'b0);
    step(1'b0, 12'd0, 7'd0, 1'b0);
    step(1'b0, 12'd0, 7'd0, 1'b0);

    // VGA priority: three writes queued under 10 cycles of vga_req.
    for (int i = 0; i < 10; i++)
      step(i < 3, 12'(i + 1), 7'(8'h61 + i), 1'b1);
    drain();

    // Range check: never queued, never flagged as overflow.
    step(1'b1, 12'd2400, 7'h11, 1'b0);
    step(1'b1, 12'd4095, 7'h12, 1'b0);
    drain();
`ifdef DISPLAY_WRITE_DROP_COUNT_EN
    check("drop_count_range", 32'(drop_count), 32'(exp_drops));
`endif

    // Overflow: nine pushes while the VGA reader blocks the port.
    for (int i = 0; i < 9; i++)
      step(1'b1, 12'(100 + i), 7'(8'h30 + i), 1'b1);
    drain();

    // Randomized traffic with random VGA contention.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) rp = 12'(SCREEN + $urandom_range(0, 4095 - SCREEN));
      else                           rp = 12'($urandom_range(0, SCREEN - 1));
      step($urandom_range(0, 99) < 60, rp, 7'($urandom_range(0, 127)),
           $urandom_range(0, 99) < 40);
    end
    drain();
    check("random_drained", 32'(exp_q.size()), 32'd0);
`ifdef DISPLAY_WRITE_DROP_COUNT_EN
    check("drop_count_random", 32'(drop_count), 32'(exp_drops > 255 ? 255 : exp_drops));
`endif

    // Clear ordering: A and B first, then the full clear, then C.
    step(1'b1, 12'd10, 7'h41, 1'b0);
    step(1'b1, 12'd20, 7'h42, 1'b0);
    clear_req = 1'b1; vga_req = 1'b0; wr_en = 1'b0;
    for (int a = 0; a < SCREEN; a++) exp_q.push_back({12'(a), 7'h20});
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 6000) begin
      @(posedge clk);
      @(negedge clk);
      clear_req = 1'b0; wr_en = 1'b0;
      vga_req = (cyc >= 20) && ($urandom_range(0, 99) < 30);
      if (cyc == 50) begin
        wr_en = 1'b1; wr_position = 12'd30; wr_char = 7'h43;
        exp_q.push_back({12'd30, 7'h43});
      end
      if (cyc == 60) clear_req = 1'b1;
      if (cyc == 80) begin
        check("clear_busy", 32'(busy), 32'd1);
        check("clear_not_full", 32'(fifo_full), 32'd0);
      end
      cyc++;
    end
    check("clear_complete", 32'(exp_q.size()), 32'd0);
    vga_req = 1'b0; clear_req = 1'b0; wr_en = 1'b0; occ = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 12'd0, 7'd0, 1'b0);

    // Reset in the middle of a clear with writes queued behind it.
    mon_en = 1'b0;
    clear_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      clear_req = 1'b0; wr_en = 1'b0;
      if (ram_we && ram_addr == 12'd500) begin
        wr_en = 1'b1; wr_position = 12'd7; wr_char = 7'h01;
      end
      if (ram_we && ram_addr == 12'd999) found = 1'b1;
    end
    check("reach_clear_addr_1000", 32'(found), 32'd1);
    rst_n = 1'b0; wr_en = 1'b0;
    #1;
    check("midclr_rst_ram_we", 32'(ram_we), 32'd0);
    check("midclr_rst_ram_addr", 32'(ram_addr), 32'd0);
    check("midclr_rst_ram_data", 32'(ram_data), 32'd0);
    check("midclr_rst_busy", 32'(busy), 32'd0);
    check("midclr_rst_overflow", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    occ = 0; exp_ovf = 1'b0; exp_drops = 0;
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50; i++) step(1'b0, 12'd0, 7'd0, 1'b0);
`ifdef DISPLAY_WRITE_DROP_COUNT_EN
    check("drop_count_after_reset", 32'(drop_count), 32'd0);
`endif

    // Normal operation resumes after the reset.
    step(1'b1, 12'd2399, 7'h7F, 1'b0);
    drain();
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
